// File: rtl/ct_ciu_ebiuif_snpresp_pkg.sv
`default_nettype none
// ============================================================================
// ct_ciu_ebiuif_snpresp_pkg : shared constants/types for the snoop-response path
// Revision: 1.0
// ============================================================================
package ct_ciu_ebiuif_snpresp_pkg;

  localparam int CR_DEPTH  = 4;
  localparam int CD_BEATS  = 4;
  localparam int CRRESP_W  = 5;
  localparam int CRRESP_DT = 0;
  localparam int CD_W      = 128;

  typedef enum logic [1:0] {
    SRC_SNB0 = 2'd0,
    SRC_SNB1 = 2'd1,
    SRC_CTCQ = 2'd2
  } cr_src_e;

  localparam logic CD_SRC_SNB0 = 1'b0;
  localparam logic CD_SRC_SNB1 = 1'b1;

  // Source 'ofs' places after 'base' in the 3-entry round-robin ring.
  function automatic cr_src_e rr_step(cr_src_e base, logic [1:0] ofs);
    logic [2:0] sum;
    sum = {1'b0, base} + {1'b0, ofs};
    if (sum >= 3'd3) sum = sum - 3'd3;
    return cr_src_e'(sum[1:0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ct_ciu_snpresp_fifo.sv
`default_nettype none
// ============================================================================
// ct_ciu_snpresp_fifo : small synchronous FIFO, wrap-bit full/empty
// Revision: 1.0
// ============================================================================
module ct_ciu_snpresp_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (pop_i)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Push into a full FIFO is legal only alongside a pop: the head slot is
  // read combinationally before the edge that overwrites it.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rptr_q[AW-1:0]];
  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/gated_clk_cell.sv
`default_nettype none
// ============================================================================
// gated_clk_cell : latch-based integrated clock gate
// Revision: 1.0
// ============================================================================
module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);

  logic en_lat;

  // Enable is captured while the clock is low so clk_out never glitches.
  always_latch begin
    if (!clk_in) begin
      en_lat <= (global_en & (module_en | local_en | external_en)) | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & en_lat;

endmodule
`default_nettype wire

// File: rtl/ct_ciu_ebiuif_snpresp.sv
`default_nettype none
// ============================================================================
// ct_ciu_ebiuif_snpresp : snoop CR queue/arbiter and ordered CD forward to EBIU
// Optional: CT_CIU_SNPRESP_CR_BYPASS_EN (same-cycle CR bypass when queue empty)
// Revision: 1.0
// ============================================================================
module ct_ciu_ebiuif_snpresp
  import ct_ciu_ebiuif_snpresp_pkg::*;
(
  input  logic                forever_cpuclk,
  input  logic                cpurst,
  input  logic                snb0_ebiuif_crvalid,
  input  logic                snb1_ebiuif_crvalid,
  input  logic                ctcq_ebiuif_crvalid,
  input  logic [CRRESP_W-1:0] snb0_ebiuif_crresp,
  input  logic [CRRESP_W-1:0] snb1_ebiuif_crresp,
  input  logic [CRRESP_W-1:0] ctcq_ebiuif_crresp,
  output logic                ebiuif_snb0_cr_grant,
  output logic                ebiuif_snb1_cr_grant,
  output logic                ebiuif_ctcq_cr_grant,
  input  logic                snb0_ebiuif_cdvalid,
  input  logic                snb1_ebiuif_cdvalid,
  input  logic [CD_W-1:0]     snb0_ebiuif_cddata,
  input  logic [CD_W-1:0]     snb1_ebiuif_cddata,
  output logic                ebiuif_snb0_cd_grant,
  output logic                ebiuif_snb1_cd_grant,
  output logic                ebiuif_ebiu_crvalid,
  output logic [CRRESP_W-1:0] ebiuif_ebiu_crresp,
  input  logic                ebiu_ebiuif_cr_grant,
  output logic                ebiuif_ebiu_cdvalid,
  output logic [CD_W-1:0]     ebiuif_ebiu_cddata,
  output logic                ebiuif_ebiu_cdlast,
  input  logic                ebiu_ebiuif_cd_grant,
  output logic                ebiuif_snpresp_idle
);

  localparam int CNT_W = $clog2(CD_BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CD_BEATS - 1);

  logic                gclk;
  logic                local_en;
  logic [2:0]          crv;
  logic [CRRESP_W-1:0] src_resp [3];
  cr_src_e             rr_ptr_q, rr_ptr_d;
  cr_src_e             win_id;
  logic                win_vld;
  logic [CRRESP_W-1:0] win_resp;
  logic                cr_ok;
  logic                cr_push, cr_pop, cr_full, cr_empty;
  logic [CRRESP_W-1:0] cr_head;
  logic                ord_push, ord_pop, ord_full, ord_empty;
  logic                ord_head;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic                beat_last;
  logic                beat_go;
  logic                sel_cdvalid;

  assign crv         = {ctcq_ebiuif_crvalid, snb1_ebiuif_crvalid, snb0_ebiuif_crvalid};
  assign src_resp[0] = snb0_ebiuif_crresp;
  assign src_resp[1] = snb1_ebiuif_crresp;
  // DVM responses from the CTC queue never carry data.
  assign src_resp[2] = {ctcq_ebiuif_crresp[CRRESP_W-1:1], 1'b0};

  assign local_en = (|crv) | ~cr_empty | ~ord_empty;

  gated_clk_cell u_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (1'b1),
    .module_en          (1'b0),
    .local_en           (local_en),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (1'b0),
    .clk_out            (gclk)
  );

  always_comb begin
    cr_src_e cand;
    win_vld = 1'b0;
    win_id  = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int k = 0; k < 3; k++) begin
      cand = rr_step(rr_ptr_q, 2'(k));
      if (!win_vld && crv[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_resp = src_resp[win_id];
  assign cr_pop   = ebiu_ebiuif_cr_grant & ~cr_empty;
  assign beat_go  = ebiuif_ebiu_cdvalid & ebiu_ebiuif_cd_grant;
  assign beat_last = (beat_cnt_q == LAST_BEAT);
  assign ord_pop  = beat_go & beat_last;

  // Blocked winner grants nobody; pop-then-push lets a full queue accept.
  assign cr_ok = win_vld & ~cpurst
               & (~cr_full | cr_pop)
               & (~win_resp[CRRESP_DT] | ~ord_full | ord_pop);

  assign ebiuif_snb0_cr_grant = cr_ok & (win_id == SRC_SNB0);
  assign ebiuif_snb1_cr_grant = cr_ok & (win_id == SRC_SNB1);
  assign ebiuif_ctcq_cr_grant = cr_ok & (win_id == SRC_CTCQ);
  assign rr_ptr_d             = cr_ok ? rr_step(win_id, 2'd1) : rr_ptr_q;

  assign ord_push = cr_ok & win_resp[CRRESP_DT];

`ifdef CT_CIU_SNPRESP_CR_BYPASS_EN
  logic cr_byp;
  assign cr_byp              = cr_ok & cr_empty;
  assign cr_push             = cr_ok & ~(cr_byp & ebiu_ebiuif_cr_grant);
  assign ebiuif_ebiu_crvalid = ~cr_empty | cr_byp;
  assign ebiuif_ebiu_crresp  = ~cr_empty ? cr_head : (cr_byp ? win_resp : '0);
`else
  assign cr_push             = cr_ok;
  assign ebiuif_ebiu_crvalid = ~cr_empty;
  assign ebiuif_ebiu_crresp  = cr_empty ? '0 : cr_head;
`endif

  ct_ciu_snpresp_fifo #(
    .WIDTH (CRRESP_W),
    .DEPTH (CR_DEPTH)
  ) u_cr_fifo (
    .clk     (gclk),
    .rst     (cpurst),
    .push_i  (cr_push),
    .data_i  (win_resp),
    .pop_i   (cr_pop),
    .data_o  (cr_head),
    .full_o  (cr_full),
    .empty_o (cr_empty)
  );

  ct_ciu_snpresp_fifo #(
    .WIDTH (1),
    .DEPTH (CR_DEPTH)
  ) u_ord_fifo (
    .clk     (gclk),
    .rst     (cpurst),
    .push_i  (ord_push),
    .data_i  (win_id == SRC_SNB1),
    .pop_i   (ord_pop),
    .data_o  (ord_head),
    .full_o  (ord_full),
    .empty_o (ord_empty)
  );

  assign sel_cdvalid = (ord_head == CD_SRC_SNB1) ? snb1_ebiuif_cdvalid : snb0_ebiuif_cdvalid;

  assign ebiuif_ebiu_cdvalid  = ~ord_empty & sel_cdvalid;
  assign ebiuif_ebiu_cddata   = ord_empty ? '0 :
                                ((ord_head == CD_SRC_SNB1) ? snb1_ebiuif_cddata : snb0_ebiuif_cddata);
  assign ebiuif_ebiu_cdlast   = ebiuif_ebiu_cdvalid & beat_last;
  assign ebiuif_snb0_cd_grant = beat_go & (ord_head == CD_SRC_SNB0);
  assign ebiuif_snb1_cd_grant = beat_go & (ord_head == CD_SRC_SNB1);

  assign beat_cnt_d = beat_go ? (beat_last ? '0 : beat_cnt_q + 1'b1) : beat_cnt_q;

  always_ff @(posedge gclk or posedge cpurst) begin
    if (cpurst) begin
      rr_ptr_q   <= SRC_SNB0;
      beat_cnt_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign ebiuif_snpresp_idle = cr_empty & ord_empty & (beat_cnt_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_ct_ciu_ebiuif_snpresp.sv
`default_nettype none
// ============================================================================
// tb_ct_ciu_ebiuif_snpresp : directed scenarios plus randomized scoreboard run
// Revision: 1.0
// ============================================================================
module tb_ct_ciu_ebiuif_snpresp;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s0v, s1v, cqv;
  logic [4:0]   s0r, s1r, cqr;
  logic         s0dv, s1dv;
  logic [127:0] s0d, s1d;
  logic         egr, ecg;
  logic         g0, g1, gq, cg0, cg1;
  logic         crvalid, cdvalid, cdlast, idle;
  logic [4:0]   crresp;
  logic [127:0] cddata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ct_ciu_ebiuif_snpresp dut (
    .forever_cpuclk       (clk),
    .cpurst               (rst),
    .snb0_ebiuif_crvalid  (s0v),
    .snb1_ebiuif_crvalid  (s1v),
    .ctcq_ebiuif_crvalid  (cqv),
    .snb0_ebiuif_crresp   (s0r),
    .snb1_ebiuif_crresp   (s1r),
    .ctcq_ebiuif_crresp   (cqr),
    .ebiuif_snb0_cr_grant (g0),
    .ebiuif_snb1_cr_grant (g1),
    .ebiuif_ctcq_cr_grant (gq),
    .snb0_ebiuif_cdvalid  (s0dv),
    .snb1_ebiuif_cdvalid  (s1dv),
    .snb0_ebiuif_cddata   (s0d),
    .snb1_ebiuif_cddata   (s1d),
    .ebiuif_snb0_cd_grant (cg0),
    .ebiuif_snb1_cd_grant (cg1),
    .ebiuif_ebiu_crvalid  (crvalid),
    .ebiuif_ebiu_crresp   (crresp),
    .ebiu_ebiuif_cr_grant (egr),
    .ebiuif_ebiu_cdvalid  (cdvalid),
    .ebiuif_ebiu_cddata   (cddata),
    .ebiuif_ebiu_cdlast   (cdlast),
    .ebiu_ebiuif_cd_grant (ecg),
    .ebiuif_snpresp_idle  (idle)
  );

  task automatic drive_idle();
    s0v = 0; s1v = 0; cqv = 0; s0r = 0; s1r = 0; cqr = 0;
    s0dv = 0; s1dv = 0; s0d = '0; s1d = '0; egr = 0; ecg = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    s0v = 1; s1v = 1; cqv = 1; s0r = 5'b00001; egr = 1; ecg = 1; s0dv = 1;
    #1;
    checks++;
    if ({g0, g1, gq, cg0, cg1} !== 5'b0) begin
      errors++; $display("FAIL reset_grants act=%b exp=00000", {g0, g1, gq, cg0, cg1});
    end
    checks++;
    if ({crvalid, crresp, cdvalid, cdlast, cddata} !== '0) begin
      errors++; $display("FAIL reset_outputs act=%b/%h/%b/%b exp=0", crvalid, crresp, cdvalid, cdlast);
    end
    checks++;
    if (idle !== 1'b1) begin
      errors++; $display("FAIL reset_idle act=%b exp=1", idle);
    end
    do_reset();
  endtask

  task automatic test_single();
    logic [127:0] d [4];
    do_reset();
    for (int i = 0; i < 4; i++) d[i] = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    s0v = 1; s0r = 5'b00001; egr = 1;
    #1;
    checks++;
    if ({g0, crvalid} !== 2'b10) begin
      errors++; $display("FAIL single_accept act=g0:%b crvalid:%b exp=g0:1 crvalid:0", g0, crvalid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s0v = 0; s0dv = 1; s0d = d[i]; ecg = 1;
      #1;
      if (i == 0) begin
        checks++;
        if ({crvalid, crresp} !== {1'b1, 5'b00001}) begin
          errors++; $display("FAIL single_cr_out act=%b/%b exp=1/00001", crvalid, crresp);
        end
      end
      checks++;
      if ({cdvalid, cg0, cdlast, cddata} !== {1'b1, 1'b1, (i == 3), d[i]}) begin
        errors++; $display("FAIL single_beat%0d act=v%b g%b l%b %h exp=v1 g1 l%b %h", i, cdvalid, cg0, cdlast, cddata, (i == 3), d[i]);
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if ({idle, cdvalid, crvalid} !== 3'b100) begin
      errors++; $display("FAIL single_idle act=%b exp=100", {idle, cdvalid, crvalid});
    end
  endtask

  task automatic test_rr();
    logic [2:0] exp_g [4];
    logic [4:0] resp_of [3];
    int         win [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    win = '{0, 1, 2, 0};
    resp_of = '{5'b00010, 5'b00100, 5'b01000};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      egr = 1;
      if (k < 4) begin
        s0v = 1; s1v = 1; cqv = 1; s0r = resp_of[0]; s1r = resp_of[1]; cqr = resp_of[2];
      end else begin
        s0v = 0; s1v = 0; cqv = 0;
      end
      #1;
      if (k < 4) begin
        checks++;
        if ({gq, g1, g0} !== exp_g[k]) begin
          errors++; $display("FAIL rr_grant%0d act=%b exp=%b", k, {gq, g1, g0}, exp_g[k]);
        end
      end
      if (k > 0) begin
        checks++;
        if ({crvalid, crresp} !== {1'b1, resp_of[win[k-1]]}) begin
          errors++; $display("FAIL rr_order%0d act=%b/%b exp=1/%b", k, crvalid, crresp, resp_of[win[k-1]]);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_cd_order();
    logic [127:0] a, b;
    do_reset();
    a = {$urandom, $urandom, $urandom, $urandom};
    b = ~a;
    @(negedge clk);
    s0v = 1; s0r = 5'b00001; egr = 1;
    #1;
    checks++;
    if (g0 !== 1'b1) begin errors++; $display("FAIL order_snb0_cr act=%b exp=1", g0); end
    for (int c = 1; c < 11; c++) begin
      @(negedge clk);
      s0v = 0; s1v = (c == 1); s1r = 5'b00001;
      s1dv = 1; s1d = b; s0d = a; ecg = 1;
      s0dv = (c >= 3 && c <= 6);
      #1;
      if (c == 1) begin
        checks++;
        if (g1 !== 1'b1) begin errors++; $display("FAIL order_snb1_cr act=%b exp=1", g1); end
      end
      checks++;
      if (c < 3) begin
        if ({cdvalid, cg0, cg1} !== 3'b000) begin
          errors++; $display("FAIL order_wait%0d act=%b exp=000", c, {cdvalid, cg0, cg1});
        end
      end else if (c <= 6) begin
        if ({cg0, cg1, cdlast, cddata} !== {1'b1, 1'b0, (c == 6), a}) begin
          errors++; $display("FAIL order_snb0_beat%0d act=g0%b g1%b l%b exp=g0 1 g1 0 l%b", c, cg0, cg1, cdlast, (c == 6));
        end
      end else begin
        if ({cg0, cg1, cdlast, cddata} !== {1'b0, 1'b1, (c == 10), b}) begin
          errors++; $display("FAIL order_snb1_beat%0d act=g0%b g1%b l%b exp=g0 0 g1 1 l%b", c, cg0, cg1, cdlast, (c == 10));
        end
      end
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL order_idle act=%b exp=1", idle); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      s0v = 1; s0r = 5'((i + 1) << 1); egr = (i == 6);
      #1;
      checks++;
      if (g0 !== ((i < 4) || (i == 6))) begin
        errors++; $display("FAIL full_grant%0d act=%b exp=%b", i, g0, ((i < 4) || (i == 6)));
      end
      if (i >= 6) begin
        checks++;
        if ({crvalid, crresp} !== {1'b1, (i == 6) ? 5'd2 : 5'd4}) begin
          errors++; $display("FAIL full_head%0d act=%b/%0d exp=1/%0d", i, crvalid, crresp, (i == 6) ? 2 : 4);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_ctcq_nodata();
    do_reset();
    @(negedge clk);
    cqv = 1; cqr = 5'b00001; egr = 1;
    #1;
    checks++;
    if (gq !== 1'b1) begin errors++; $display("FAIL ctcq_grant act=%b exp=1", gq); end
    @(negedge clk);
    cqv = 0; s0dv = 1; ecg = 1;
    #1;
    checks++;
    if ({crvalid, crresp, cdvalid, cg0} !== {1'b1, 5'b00000, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ctcq_nodata act=%b/%b/%b/%b exp=1/00000/0/0", crvalid, crresp, cdvalid, cg0);
    end
    @(negedge clk);
    drive_idle();
    #1;
    checks++;
    if (idle !== 1'b1) begin errors++; $display("FAIL ctcq_idle act=%b exp=1", idle); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    s0v = 1; s0r = 5'b00001; egr = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      s0v = 0; s0dv = 1; ecg = 1; s0d = {4{$urandom}};
    end
    @(negedge clk);
    rst = 1; s0v = 1;
    #1;
    checks++;
    if ({g0, cg0, crvalid, cdvalid, cdlast, idle} !== 6'b000001) begin
      errors++; $display("FAIL midreset_state act=%b exp=000001", {g0, cg0, crvalid, cdvalid, cdlast, idle});
    end
    @(negedge clk);
    rst = 0; s0dv = 0;
    #1;
    checks++;
    if (g0 !== 1'b1) begin errors++; $display("FAIL midreset_new_cr act=%b exp=1", g0); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      s0v = 0; s0dv = 1;
      #1;
      checks++;
      if ({cg0, cdlast} !== {1'b1, (i == 3)}) begin
        errors++; $display("FAIL midreset_beat%0d act=g%b l%b exp=g1 l%b", i, cg0, cdlast, (i == 3));
      end
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [4:0] crq [$];
    int         ordq [$];
    int         ptr, cnt, win;
    logic [4:0] rsp [3];
    logic [2:0] vv;
    logic [4:0] e_resp, w_resp;
    logic [127:0] e_data;
    logic       e_crv, e_cdv, e_last, ok, crpop, ordpop, byp;
    logic [2:0] e_g;
    logic [1:0] e_cg;
    ptr = 0; cnt = 0;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      s0v = ($urandom_range(0, 9) < 6); s1v = ($urandom_range(0, 9) < 5); cqv = ($urandom_range(0, 9) < 3);
      s0r = 5'($urandom); s1r = 5'($urandom); cqr = 5'($urandom);
      s0dv = ($urandom_range(0, 9) < 7); s1dv = ($urandom_range(0, 9) < 7);
      s0d = {$urandom, $urandom, $urandom, $urandom}; s1d = {$urandom, $urandom, $urandom, $urandom};
      egr = ($urandom_range(0, 9) < 5); ecg = ($urandom_range(0, 9) < 7);
      #1;
      vv = {cqv, s1v, s0v};
      rsp[0] = s0r; rsp[1] = s1r; rsp[2] = cqr & 5'b11110;
      e_cdv  = (ordq.size() > 0) && ((ordq[0] == 0) ? s0dv : s1dv);
      e_data = (ordq.size() > 0) ? ((ordq[0] == 0) ? s0d : s1d) : '0;
      e_last = e_cdv && (cnt == 3);
      e_cg   = (e_cdv && ecg) ? ((ordq[0] == 0) ? 2'b01 : 2'b10) : 2'b00;
      crpop  = egr && (crq.size() > 0);
      ordpop = e_cdv && ecg && (cnt == 3);
      win = -1;
      for (int k = 0; k < 3; k++) if (win < 0 && vv[(ptr + k) % 3]) win = (ptr + k) % 3;
      w_resp = (win >= 0) ? rsp[win] : 5'd0;
      ok = (win >= 0) && (crq.size() < 4 || crpop) && (!w_resp[0] || ordq.size() < 4 || ordpop);
      e_g = ok ? 3'(1 << win) : 3'b000;
      e_crv  = (crq.size() > 0);
      e_resp = (crq.size() > 0) ? crq[0] : 5'd0;
      byp = 1'b0;
`ifdef CT_CIU_SNPRESP_CR_BYPASS_EN
      if (crq.size() == 0 && ok) begin
        e_crv = 1'b1; e_resp = w_resp; byp = egr;
      end
`endif
      checks++;
      if ({gq, g1, g0} !== e_g) begin
        errors++; $display("FAIL rand_cr_grant cyc%0d act=%b exp=%b", cyc, {gq, g1, g0}, e_g);
      end
      checks++;
      if ({crvalid, crresp} !== {e_crv, e_resp}) begin
        errors++; $display("FAIL rand_cr_out cyc%0d act=%b/%b exp=%b/%b", cyc, crvalid, crresp, e_crv, e_resp);
      end
      checks++;
      if ({cdvalid, cdlast, cg1, cg0} !== {e_cdv, e_last, e_cg}) begin
        errors++; $display("FAIL rand_cd_ctl cyc%0d act=%b exp=%b", cyc, {cdvalid, cdlast, cg1, cg0}, {e_cdv, e_last, e_cg});
      end
      checks++;
      if (cddata !== e_data) begin
        errors++; $display("FAIL rand_cd_data cyc%0d act=%h exp=%h", cyc, cddata, e_data);
      end
      checks++;
      if (idle !== (crq.size() == 0 && ordq.size() == 0 && cnt == 0)) begin
        errors++; $display("FAIL rand_idle cyc%0d act=%b", cyc, idle);
      end
      if (crpop) void'(crq.pop_front());
      if (ok) begin
        if (!byp) crq.push_back(w_resp);
        if (w_resp[0]) ordq.push_back(win);
        ptr = (win + 1) % 3;
      end
      if (e_cdv && ecg) begin
        if (cnt == 3) begin cnt = 0; void'(ordq.pop_front()); end
        else cnt++;
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_rr();
    test_cd_order();
    test_full();
    test_ctcq_nodata();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
